// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM pipeline stage.
// Holds access-size and branch-mode encodings, the default data segment base,
// and the fault-check and load-extension functions used by the stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } access_size_e;

  typedef enum logic [1:0] {
    BR_NONE     = 2'b00,
    BR_EQ       = 2'b01,
    BR_NE       = 2'b10,
    BR_NONE_ALT = 2'b11
  } branch_mode_e;

  localparam logic [31:0] DEFAULT_DATA_BASE = 32'h1001_0000;

  // Reserved size, misalignment for the size, or address outside the data segment.
  function automatic logic access_fault(access_size_e size, logic [1:0] lane,
                                        logic below_base, logic out_of_range);
    logic misaligned;
    misaligned = ((size == SIZE_HALF) && lane[0]) ||
                 ((size == SIZE_WORD) && (lane != 2'b00));
    return (size == SIZE_RSVD) || misaligned || below_base || out_of_range;
  endfunction

  // Pick the addressed byte/half out of a little-endian word and extend it.
  function automatic logic [31:0] extend_load(logic [31:0] word, access_size_e size,
                                              logic [1:0] lane, logic is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      SIZE_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      SIZE_WORD: r = word;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// EX/MEM -> MEM/WB bundle for the MEM stage plus branch resolution results.
// slave is the stage itself; master is whatever drives EX/MEM and consumes MEM/WB.
interface mem_access_stage_if #(parameter int NBits = 32);
  import mem_stage_pkg::*;

  logic             valid_in;
  logic             stall;
  logic             flush;
  logic             MemWrite;
  logic             MemRead;
  access_size_e     AccessSize;
  logic             LoadUnsigned;
  branch_mode_e     BranchMode;
  logic             Zero;
  logic [NBits-1:0] ALUResult;
  logic [NBits-1:0] ReadData2;
  logic [NBits-1:0] PC_4;
  logic [NBits-1:0] BranchAddress;

  logic [NBits-1:0] MemoryData;
  logic [NBits-1:0] ALUResult_wb;
  logic             valid_out;
  logic             fault_out;
  logic             fault_sticky;
  logic             BranchTaken;
  logic [NBits-1:0] PCOrBranch;

  modport slave (
    input  valid_in, stall, flush, MemWrite, MemRead, AccessSize, LoadUnsigned,
           BranchMode, Zero, ALUResult, ReadData2, PC_4, BranchAddress,
    output MemoryData, ALUResult_wb, valid_out, fault_out, fault_sticky,
           BranchTaken, PCOrBranch
  );

  modport master (
    output valid_in, stall, flush, MemWrite, MemRead, AccessSize, LoadUnsigned,
           BranchMode, Zero, ALUResult, ReadData2, PC_4, BranchAddress,
    input  MemoryData, ALUResult_wb, valid_out, fault_out, fault_sticky,
           BranchTaken, PCOrBranch
  );
endinterface

// File: rtl/data_memory_bytelane.sv
// Word-organised data RAM with per-byte write enables and a registered read port.
// Read data appears one cycle after the address; re=0 holds the previous read.
// The array is not reset so contents survive a pipeline reset.
module data_memory_bytelane #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic          re,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write and read-first synchronous read.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: address translation, sub-word load/store, fault detection, MEM/WB register.
// Loads return one cycle after the address edge; branch outcome is combinational.
// stall freezes MEM/WB and blocks writes; flush squashes the instruction and wins over stall.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int          NBits        = 32,
  parameter int          MEMORY_DEPTH = 512,
  parameter logic [31:0] DATA_BASE    = DEFAULT_DATA_BASE
) (
  input  logic               clk,
  input  logic               reset,
  mem_access_stage_if.slave  bus
);

  localparam int          AW        = $clog2(MEMORY_DEPTH);
  localparam logic [31:0] MEM_BYTES = 32'(4 * MEMORY_DEPTH);

  if (NBits != 32) begin : g_width_check
    $error("mem_access_stage: only NBits=32 is supported");
  end

  logic [31:0]  offset;
  logic [1:0]   lane;
  logic         below_base;
  logic         out_of_range;
  logic         access;
  logic         fault;
  logic         wr_en;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  access_size_e size;

  logic         valid_q;
  logic         fault_q;
  logic         sticky_q;
  logic         load_q;
  logic         uns_q;
  logic [1:0]   lane_q;
  access_size_e size_q;
  logic [31:0]  alu_q;

  // Address translation, fault decision and store lane/data steering.
  always_comb begin
    size         = bus.AccessSize;
    offset       = bus.ALUResult - DATA_BASE;
    lane         = offset[1:0];
    below_base   = bus.ALUResult < DATA_BASE;
    out_of_range = offset >= MEM_BYTES;
    access       = bus.valid_in & (bus.MemRead | bus.MemWrite);
    fault        = access & access_fault(size, lane, below_base, out_of_range);
    // reset term keeps an access that is aborted by reset from committing.
    wr_en        = access & bus.MemWrite & ~fault & ~bus.stall & ~bus.flush & reset;
    wr_be        = 4'b0000;
    wr_data      = bus.ReadData2;
    case (size)
      SIZE_BYTE: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{bus.ReadData2[7:0]}};
      end
      SIZE_HALF: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.ReadData2[15:0]}};
      end
      SIZE_WORD: wr_be = 4'b1111;
      default:   wr_be = 4'b0000;
    endcase
  end

  data_memory_bytelane #(.DEPTH(MEMORY_DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .be    (wr_be),
    .addr  (offset[AW+1:2]),
    .wdata (wr_data),
    .re    (~bus.stall),
    .rdata (rd_data)
  );

  // MEM/WB register: lane/size/extension/fault captured alongside the RAM read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
      load_q   <= 1'b0;
      uns_q    <= 1'b0;
      lane_q   <= 2'b00;
      size_q   <= SIZE_BYTE;
      alu_q    <= '0;
    end else if (bus.flush) begin
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      load_q   <= 1'b0;
      alu_q    <= '0;
    end else if (!bus.stall) begin
      valid_q  <= bus.valid_in;
      fault_q  <= fault;
      // Only clean pure loads produce data; faults and read+write return zero.
      load_q   <= access & bus.MemRead & ~bus.MemWrite & ~fault;
      uns_q    <= bus.LoadUnsigned;
      lane_q   <= lane;
      size_q   <= size;
      alu_q    <= bus.ALUResult;
      if (fault) sticky_q <= 1'b1;
    end
  end

  assign bus.MemoryData   = load_q ? extend_load(rd_data, size_q, lane_q, uns_q) : '0;
  assign bus.ALUResult_wb = alu_q;
  assign bus.valid_out    = valid_q;
  assign bus.fault_out    = fault_q;
  assign bus.fault_sticky = sticky_q;

  // Branch resolution is left ungated by stall/flush; the hazard unit owns that.
  assign bus.BranchTaken = bus.valid_in &
                           (((bus.BranchMode == BR_EQ) & bus.Zero) |
                            ((bus.BranchMode == BR_NE) & ~bus.Zero));
  assign bus.PCOrBranch  = bus.BranchTaken ? bus.BranchAddress : bus.PC_4;

endmodule
